// File: rtl/seq_game_pkg.sv
// Shared types and elaboration helpers for the sequence-memory game core.
package seq_game_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_SHOW  = 3'd2,
      S_GAP   = 3'd3,
      S_WAIT  = 3'd4,
      S_CHECK = 3'd5,
      S_WIN   = 3'd6,
      S_LOSE  = 3'd7
   } game_state_t;

   // Triangle walk over the notes: 0,1,..,N-1,N-2,..,1,0,1,...
   function automatic int unsigned zigzag(input int unsigned idx, input int unsigned notes);
      int unsigned period;
      int unsigned k;
      period = 2 * (notes - 1);
      k      = idx % period;
      return (k < notes) ? k : period - k;
   endfunction

   function automatic int unsigned base_points(input int unsigned r, input int unsigned rounds,
                                               input int unsigned score_max);
      return (r * score_max) / ((rounds * (rounds + 1)) / 2);
   endfunction

endpackage

// File: rtl/seq_press_detect.sv
// Two-flop button synchroniser with rising-edge detect on the OR of all buttons.
module seq_press_detect #(
   parameter int NOTES = 7
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [NOTES-1:0] buttons,
   output logic [NOTES-1:0] sync,
   output logic             press
);

   logic [NOTES-1:0] meta;
   logic             any_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta  <= '0;
         sync  <= '0;
         any_q <= 1'b0;
      end else begin
         meta  <= buttons;
         sync  <= meta;
         any_q <= |sync;
      end
   end

   assign press = (|sync) & ~any_q;

endmodule

// File: rtl/seq_game_core.sv
// Sequence-memory game: show a growing note sequence, check player presses, keep score.
// Define SEQ_GAME_CORE_LFSR_EN for an LFSR-filled sequence; default is a fixed zigzag.
module seq_game_core
   import seq_game_pkg::*;
#(
   parameter int NOTES       = 7,
   parameter int DEPTH       = 16,
   parameter int SHOW_CYC    = 500,
   parameter int TIMEOUT_CYC = 5000,
   parameter int MAX_ERR     = 3,
   parameter int PENALTY     = 2,
   parameter int SCORE_MAX   = 100
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             level,
   input  logic [NOTES-1:0]                 buttons,
   output logic [NOTES-1:0]                 leds,
   output logic [$clog2(NOTES+1)-1:0]       note_out,
   output logic [$clog2(SCORE_MAX+1)-1:0]   score,
   output logic [$clog2(MAX_ERR+1)-1:0]     errors,
   output logic [$clog2(DEPTH+1)-1:0]       round,
   output logic                             busy,
   output logic                             won,
   output logic                             lost,
   output logic [2:0]                       db_state
);

   localparam int NW   = $clog2(NOTES);
   localparam int OW   = $clog2(NOTES+1);
   localparam int IW   = $clog2(DEPTH);
   localparam int RW   = $clog2(DEPTH+1);
   localparam int SW   = $clog2(SCORE_MAX+1);
   localparam int EW   = $clog2(MAX_ERR+1);
   localparam int CMAX = (SHOW_CYC > TIMEOUT_CYC) ? SHOW_CYC : TIMEOUT_CYC;
   localparam int CW   = $clog2(CMAX+1);

   function automatic logic [NOTES-1:0] onehot(input logic [NW-1:0] n);
      return NOTES'(1) << n;
   endfunction

   game_state_t      state;
   logic [IW-1:0]    idx;
   logic [CW-1:0]    cnt;
   logic             level_q;
   logic [NOTES-1:0] btn_q;
   logic [EW-1:0]    round_errors;
   logic [NOTES-1:0] sync;
   logic             press;
   logic [NW-1:0]    cur_note, next_note, first_note;
   logic             fill_done, start_ok, last_note, match, miss;
   logic [RW-1:0]    last_round;
   logic [OW-1:0]    held_note, n_held;
   logic [SW-1:0]    score_next;
   logic [31:0]      base_w, pen_w, gain_w, sum_w;
   logic [SW-1:0]    base_half [DEPTH+1];
   logic [SW-1:0]    base_full [DEPTH+1];

   seq_press_detect #(.NOTES(NOTES)) u_press (
      .clock   (clock),
      .reset   (reset),
      .buttons (buttons),
      .sync    (sync),
      .press   (press)
   );

   for (genvar r = 0; r <= DEPTH; r++) begin : g_base
      assign base_half[r] = SW'(base_points(r, DEPTH/2, SCORE_MAX));
      assign base_full[r] = SW'(base_points(r, DEPTH, SCORE_MAX));
   end

   assign start_ok = start && (state == S_IDLE || state == S_WIN || state == S_LOSE);

`ifdef SEQ_GAME_CORE_LFSR_EN
   logic [NW-1:0] seq_mem [DEPTH];
   logic [15:0]   lfsr, free_cnt;

   // idx doubles as the fill pointer while in FILL.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         free_cnt <= '0;
         lfsr     <= '0;
         for (int unsigned k = 0; k < DEPTH; k++) seq_mem[k] <= '0;
      end else begin
         free_cnt <= free_cnt + 16'd1;
         if (start_ok) begin
            lfsr <= (free_cnt == 16'd0) ? 16'd1 : free_cnt;
         end else if (state == S_FILL) begin
            seq_mem[idx] <= NW'(lfsr % 16'(NOTES));
            lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         end
      end
   end

   assign fill_done  = (idx == IW'(DEPTH-1));
   assign cur_note   = seq_mem[idx];
   assign next_note  = seq_mem[idx + IW'(1)];
   assign first_note = seq_mem[0];
`else
   assign fill_done  = 1'b1;
   assign cur_note   = NW'(zigzag(32'(idx), NOTES));
   assign next_note  = NW'(zigzag(32'(idx) + 32'd1, NOTES));
   assign first_note = NW'(zigzag(32'd0, NOTES));
`endif

   assign last_round = level_q ? RW'(DEPTH) : RW'(DEPTH/2);
   assign last_note  = (RW'(idx) == round - RW'(1));
   assign match      = (btn_q == onehot(cur_note));
   assign miss       = (state == S_WAIT && !press && cnt == CW'(TIMEOUT_CYC-1)) ||
                       (state == S_CHECK && !match);
   assign db_state   = state;

   always_comb begin
      held_note = '0;
      n_held    = '0;
      for (int unsigned b = 0; b < NOTES; b++) begin
         if (sync[b]) begin
            held_note = OW'(b + 1);
            n_held    = n_held + OW'(1);
         end
      end
      if (n_held != OW'(1)) held_note = '0;
   end

   always_comb begin
      base_w     = level_q ? 32'(base_full[round]) : 32'(base_half[round]);
      pen_w      = 32'(PENALTY) * 32'(round_errors);
      gain_w     = (base_w > pen_w) ? base_w - pen_w : 32'd0;
      sum_w      = 32'(score) + gain_w;
      score_next = (sum_w > 32'(SCORE_MAX)) ? SW'(SCORE_MAX) : SW'(sum_w);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         idx          <= '0;
         cnt          <= '0;
         level_q      <= 1'b0;
         btn_q        <= '0;
         round_errors <= '0;
         score        <= '0;
         errors       <= '0;
         round        <= '0;
         leds         <= '0;
         note_out     <= '0;
         busy         <= 1'b0;
         won          <= 1'b0;
         lost         <= 1'b0;
      end else if (start_ok) begin
         state        <= S_FILL;
         level_q      <= level;
         score        <= '0;
         errors       <= '0;
         round_errors <= '0;
         round        <= RW'(1);
         idx          <= '0;
         cnt          <= '0;
         leds         <= '0;
         note_out     <= '0;
         busy         <= 1'b1;
         won          <= 1'b0;
         lost         <= 1'b0;
      end else begin
         case (state)
            S_FILL: begin
               if (fill_done) begin
                  state    <= S_SHOW;
                  idx      <= '0;
                  cnt      <= '0;
                  leds     <= onehot(first_note);
                  note_out <= OW'(first_note) + OW'(1);
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            S_SHOW: begin
               if (cnt == CW'(SHOW_CYC-1)) begin
                  state    <= S_GAP;
                  cnt      <= '0;
                  leds     <= '0;
                  note_out <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_GAP: begin
               if (cnt == CW'(SHOW_CYC-1)) begin
                  cnt <= '0;
                  if (last_note) begin
                     state <= S_WAIT;
                     idx   <= '0;
                  end else begin
                     state    <= S_SHOW;
                     idx      <= idx + IW'(1);
                     leds     <= onehot(next_note);
                     note_out <= OW'(next_note) + OW'(1);
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_WAIT: begin
               leds     <= sync;
               note_out <= held_note;
               if (press) begin
                  btn_q <= sync;
                  state <= S_CHECK;
                  cnt   <= '0;
               end else if (cnt != CW'(TIMEOUT_CYC-1)) begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_CHECK: begin
               if (match && !last_note) begin
                  idx   <= idx + IW'(1);
                  state <= S_WAIT;
                  cnt   <= '0;
               end else if (match && round == last_round) begin
                  state    <= S_WIN;
                  score    <= (errors == '0) ? SW'(SCORE_MAX) : score_next;
                  won      <= 1'b1;
                  busy     <= 1'b0;
                  leds     <= '1;
                  note_out <= '0;
               end else if (match) begin
                  score        <= score_next;
                  round        <= round + RW'(1);
                  round_errors <= '0;
                  state        <= S_SHOW;
                  idx          <= '0;
                  cnt          <= '0;
                  leds         <= onehot(first_note);
                  note_out     <= OW'(first_note) + OW'(1);
               end
            end
            default: ;
         endcase

         // Timeouts and wrong presses share one path; it overrides the WAIT mirror above.
         if (miss) begin
            errors       <= errors + EW'(1);
            round_errors <= round_errors + EW'(1);
            if (errors == EW'(MAX_ERR-1)) begin
               state    <= S_LOSE;
               lost     <= 1'b1;
               busy     <= 1'b0;
               leds     <= '0;
               note_out <= '0;
            end else begin
               state    <= S_SHOW;
               idx      <= '0;
               cnt      <= '0;
               leds     <= onehot(first_note);
               note_out <= OW'(first_note) + OW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_game_core.sv
// Randomised-timing bench for seq_game_core with a round/score reference model.
module tb_seq_game_core;

   localparam int NOTES       = 7;
   localparam int DEPTH       = 16;
   localparam int SHOW_CYC    = 500;
   localparam int TIMEOUT_CYC = 5000;
   localparam int MAX_ERR     = 3;
   localparam int PENALTY     = 2;
   localparam int SCORE_MAX   = 100;
   localparam int L0          = DEPTH / 2;
   localparam int BUDGET      = 2 * SHOW_CYC * DEPTH + TIMEOUT_CYC + 100;
   localparam logic [2:0] ST_IDLE = 3'd0, ST_SHOW = 3'd2, ST_GAP = 3'd3,
                          ST_WAIT = 3'd4, ST_WIN = 3'd6, ST_LOSE = 3'd7;

   logic                             clock = 1'b0;
   logic                             reset, start, level;
   logic [NOTES-1:0]                 buttons, leds;
   logic [$clog2(NOTES+1)-1:0]       note_out;
   logic [$clog2(SCORE_MAX+1)-1:0]   score;
   logic [$clog2(MAX_ERR+1)-1:0]     errors;
   logic [$clog2(DEPTH+1)-1:0]       round;
   logic                             busy, won, lost;
   logic [2:0]                       db_state;

   int n_total = 0;
   int n_bad   = 0;
   int zig [DEPTH];
   int m_score, m_errors, m_round, m_rerr;

   seq_game_core #(
      .NOTES(NOTES), .DEPTH(DEPTH), .SHOW_CYC(SHOW_CYC), .TIMEOUT_CYC(TIMEOUT_CYC),
      .MAX_ERR(MAX_ERR), .PENALTY(PENALTY), .SCORE_MAX(SCORE_MAX)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .level(level), .buttons(buttons),
      .leds(leds), .note_out(note_out), .score(score), .errors(errors), .round(round),
      .busy(busy), .won(won), .lost(lost), .db_state(db_state)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int base_pts(input int r, input int l);
      return (r * SCORE_MAX) / (l * (l + 1) / 2);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic wait_state(input logic [2:0] s, input string tag);
      int n = 0;
      while (db_state != s && n < BUDGET) begin
         @(negedge clock);
         n++;
      end
      check_eq(tag, int'(db_state), int'(s));
   endtask

   task automatic pulse_start(input logic lv);
      start = 1'b1;
      level = lv;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
   endtask

   task automatic new_game();
      pulse_start(1'b0);
      m_score = 0; m_errors = 0; m_round = 1; m_rerr = 0;
      check_eq("start_round", int'(round), 1);
      check_eq("start_score", int'(score), 0);
      check_eq("start_busy", int'(busy), 1);
      check_eq("start_flags", int'({won, lost}), 0);
   endtask

   // Holds a button vector long enough for the core to judge it, checking the WAIT mirror.
   task automatic press(input logic [NOTES-1:0] vec, input string tag);
      int hold = int'($urandom_range(4, 7));
      int exp_note = 0;
      for (int b = 0; b < NOTES; b++)
         if (vec == (NOTES'(1) << b)) exp_note = b + 1;
      tick(int'($urandom_range(0, 5)));
      buttons = vec;
      for (int k = 0; k < hold; k++) begin
         @(negedge clock);
         if (k == 2) begin
            check_eq({tag, "_leds"}, int'(leds), int'(vec));
            check_eq({tag, "_note"}, int'(note_out), exp_note);
         end
      end
      buttons = '0;
      @(negedge clock);
   endtask

   task automatic play_round(input string tag);
      int g;
      for (int j = 0; j < m_round; j++) begin
         wait_state(ST_WAIT, {tag, "_wait"});
         press(NOTES'(1) << zig[j], tag);
      end
      g = base_pts(m_round, L0) - PENALTY * m_rerr;
      if (g < 0) g = 0;
      m_score = (m_score + g > SCORE_MAX) ? SCORE_MAX : m_score + g;
      if (m_round == L0) begin
         if (m_errors == 0) m_score = SCORE_MAX;
         check_eq({tag, "_won"}, int'(won), 1);
      end else begin
         m_round++;
         m_rerr = 0;
         check_eq({tag, "_round"}, int'(round), m_round);
      end
      check_eq({tag, "_score"}, int'(score), m_score);
      check_eq({tag, "_errors"}, int'(errors), m_errors);
   endtask

   task automatic miss_press(input logic [NOTES-1:0] vec, input string tag);
      wait_state(ST_WAIT, {tag, "_wait"});
      press(vec, tag);
      m_errors++;
      m_rerr++;
      check_eq({tag, "_errors"}, int'(errors), m_errors);
      if (m_errors == MAX_ERR) begin
         check_eq({tag, "_lost"}, int'(lost), 1);
         check_eq({tag, "_busy"}, int'(busy), 0);
         check_eq({tag, "_state"}, int'(db_state), int'(ST_LOSE));
         check_eq({tag, "_leds_off"}, int'(leds), 0);
      end else begin
         check_eq({tag, "_replay"}, int'(db_state), int'(ST_SHOW));
         check_eq({tag, "_round"}, int'(round), m_round);
      end
   endtask

   task automatic timeout_round(input string tag);
      int n = 0;
      wait_state(ST_WAIT, {tag, "_wait"});
      while (db_state == ST_WAIT && n < TIMEOUT_CYC + 50) begin
         n++;
         @(negedge clock);
      end
      m_errors++;
      m_rerr++;
      check_eq({tag, "_wait_len"}, n, TIMEOUT_CYC);
      check_eq({tag, "_errors"}, int'(errors), m_errors);
      check_eq({tag, "_round"}, int'(round), m_round);
      check_eq({tag, "_replay"}, int'(db_state), int'(ST_SHOW));
   endtask

   initial begin
      #2_000_000;
      check_eq("watchdog", 1, 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, bad, v, up, a, b;
      logic [NOTES-1:0] vec;

      v = 0; up = 1;
      for (int i = 0; i < DEPTH; i++) begin
         zig[i] = v;
         if (up == 1 && v == NOTES - 1) up = 0;
         else if (up == 0 && v == 0) up = 1;
         v = up ? v + 1 : v - 1;
      end

      reset = 1'b1; start = 1'b0; level = 1'b0; buttons = '0;
      tick(3);
      check_eq("rst_state", int'(db_state), int'(ST_IDLE));
      check_eq("rst_outputs", int'({leds, note_out, score, errors, round, busy, won, lost}), 0);
      reset = 1'b0;
      tick(2);

      // Game A: perfect play through all short-level rounds.
      new_game();
      wait_state(ST_SHOW, "a_show");
      n = 0; bad = 0;
      while (db_state == ST_SHOW && n < SHOW_CYC + 50) begin
         if (leds != (NOTES'(1) << zig[0]) || int'(note_out) != zig[0] + 1) bad++;
         n++;
         @(negedge clock);
      end
      check_eq("a_show_len", n, SHOW_CYC);
      check_eq("a_show_bad_samples", bad, 0);
      n = 0; bad = 0;
      while (db_state == ST_GAP && n < SHOW_CYC + 50) begin
         if (leds != '0 || note_out != '0) bad++;
         n++;
         @(negedge clock);
      end
      check_eq("a_gap_len", n, SHOW_CYC);
      check_eq("a_gap_bad_samples", bad, 0);
      for (int r = 1; r <= L0; r++) begin
         play_round($sformatf("a_r%0d", r));
         if (r == 2) begin
            pulse_start(1'b1);
            check_eq("a_busy_start_state", int'(db_state), int'(ST_SHOW));
            check_eq("a_busy_start_round", int'(round), 3);
         end
      end
      check_eq("a_final_score", int'(score), SCORE_MAX);
      check_eq("a_final_state", int'(db_state), int'(ST_WIN));
      check_eq("a_final_busy", int'(busy), 0);
      check_eq("a_final_leds", int'(leds), (1 << NOTES) - 1);
      check_eq("a_final_note", int'(note_out), 0);
      tick(20);
      check_eq("a_win_hold", int'({won, lost}), 2);

      // Game B: wrong press, timeout, then a multi-hot press ends it.
      new_game();
      play_round("b_r1");
      a = (zig[0] + 1 + int'($urandom_range(0, NOTES - 2))) % NOTES;
      miss_press(NOTES'(1) << a, "b_r2_wrong");
      play_round("b_r2");
      check_eq("b_r2_score_fixed", int'(score), 5);
      timeout_round("b_r3_to");
      play_round("b_r3");
      a = int'($urandom_range(0, NOTES - 1));
      b = (a + 1 + int'($urandom_range(0, NOTES - 2))) % NOTES;
      vec = (NOTES'(1) << a) | (NOTES'(1) << b);
      miss_press(vec, "b_r4_multi");

      // Game C: three double presses in round 1.
      new_game();
      wait_state(ST_SHOW, "c_show");
      pulse_start(1'b1);
      check_eq("c_busy_start_state", int'(db_state), int'(ST_SHOW));
      for (int e = 0; e < MAX_ERR; e++)
         miss_press(7'b0000011, $sformatf("c_dbl%0d", e));

      // Game D: asynchronous reset in the middle of SHOW.
      new_game();
      wait_state(ST_SHOW, "d_show");
      tick(int'($urandom_range(10, 100)));
      #2 reset = 1'b1;
      @(negedge clock);
      check_eq("d_rst_state", int'(db_state), int'(ST_IDLE));
      check_eq("d_rst_outputs", int'({leds, note_out, score, errors, round, busy, won, lost}), 0);
      reset = 1'b0;
      tick(2);
      new_game();
      wait_state(ST_SHOW, "d_restart_show");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
